// File: rtl/data_memory_unit.sv
// data_memory_unit
//   256-byte big-endian data RAM for the MEM stage. Byte, halfword and word
//   loads/stores with optional sign extension on loads. The read path is
//   registered: a load presented in cycle N is answered in cycle N+1.
//
//   Optional build macro: DMEM_ALIGN_CHECK_EN
//     defined   - misaligned halfword/word accesses fault (err, no write,
//                 load returns 0)
//     undefined - misaligned addresses are aligned down; only req_size = 11
//                 faults
//
// Ports
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset (RAM contents are kept)
//   req_valid   access request this cycle
//   req_we      1 = store, 0 = load
//   req_size    00 byte, 01 halfword, 10 word, 11 reserved (faults)
//   req_signed  loads: 1 = sign-extend byte/halfword
//   addr        byte address
//   data_in     store data, right-justified
//   data_out    load result, valid while rsp_valid = 1
//   rsp_valid   pulse one cycle after a load
//   err         pulse one cycle after a faulting request
//   busy_cnt    saturating count of accepted requests since reset

module data_memory_unit #(
  parameter int DEPTH   = 256,
  parameter int INIT_DW = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [INIT_DW-1:0]       data_in,
  output logic [INIT_DW-1:0]       data_out,
  output logic                     rsp_valid,
  output logic                     err,
  output logic [7:0]               busy_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic [7:0] mem [DEPTH];

  logic [INIT_DW-1:0] data_out_q, data_out_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               err_q, err_d;
  logic [7:0]         busy_cnt_q, busy_cnt_d;

  logic               fault;
  logic               wr_en;
  logic [AW-1:0]      base, a0, a1, a2, a3;
  logic [7:0]         b0, b1, b2, b3;
  logic [INIT_DW-1:0] load_val;

  always_comb begin
    fault = (req_size == 2'b11);
`ifdef DMEM_ALIGN_CHECK_EN
    if (req_size == SIZE_HALF && addr[0])          fault = 1'b1;
    if (req_size == SIZE_WORD && addr[1:0] != 2'b00) fault = 1'b1;
    base = addr;
`else
    // Silently align down to the natural boundary of the access size.
    case (req_size)
      SIZE_HALF: base = {addr[AW-1:1], 1'b0};
      SIZE_WORD: base = {addr[AW-1:2], 2'b00};
      default:   base = addr;
    endcase
`endif
  end

  // Byte lanes, most-significant first; the adds wrap modulo DEPTH.
  assign a0 = base;
  assign a1 = base + AW'(1);
  assign a2 = base + AW'(2);
  assign a3 = base + AW'(3);

  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    load_val = '0;
    case (req_size)
      SIZE_BYTE: load_val = {{24{req_signed & b0[7]}}, b0};
      SIZE_HALF: load_val = {{16{req_signed & b0[7]}}, b0, b1};
      SIZE_WORD: load_val = {b0, b1, b2, b3};
      default:   load_val = '0;
    endcase
  end

  always_comb begin
    data_out_d  = data_out_q;
    rsp_valid_d = 1'b0;
    err_d       = 1'b0;
    busy_cnt_d  = busy_cnt_q;
    wr_en       = 1'b0;
    if (req_valid) begin
      err_d = fault;
      if (busy_cnt_q != 8'hFF) busy_cnt_d = busy_cnt_q + 8'd1;
      if (req_we) begin
        wr_en = ~fault;
      end else begin
        rsp_valid_d = 1'b1;
        data_out_d  = fault ? '0 : load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out_q  <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_cnt_q  <= 8'h00;
    end else begin
      data_out_q  <= data_out_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      busy_cnt_q  <= busy_cnt_d;
      // Storage is not reset; a request during reset is dropped entirely.
      if (wr_en) begin
        case (req_size)
          SIZE_BYTE: mem[a0] <= data_in[7:0];
          SIZE_HALF: begin
            mem[a0] <= data_in[15:8];
            mem[a1] <= data_in[7:0];
          end
          SIZE_WORD: begin
            mem[a0] <= data_in[31:24];
            mem[a1] <= data_in[23:16];
            mem[a2] <= data_in[15:8];
            mem[a3] <= data_in[7:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out  = data_out_q;
  assign rsp_valid = rsp_valid_q;
  assign err       = err_q;
  assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_data_memory_unit.sv
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [7:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        rsp_valid;
  logic        err;
  logic [7:0]  busy_cnt;

  data_memory_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .rsp_valid  (rsp_valid),
    .err        (err),
    .busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rsp;
    logic        err;
    logic [31:0] data;
    logic [7:0]  busy;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ref_mem [256];
  logic [31:0] last_data;
  logic [7:0]  ref_busy;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_fault(input logic [1:0] size, input logic [7:0] a);
    if (size == 2'b11) return 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
    if (size == 2'b01 && a[0]) return 1'b1;
    if (size == 2'b10 && a[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [7:0] base_of(input logic [1:0] size, input logic [7:0] a);
    if (size == 2'b01) return a & 8'hFE;
    if (size == 2'b10) return a & 8'hFC;
    return a;
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [7:0] a);
    logic [31:0] v;
    logic [7:0]  b;
    int          n;
    if (is_fault(size, a)) return 32'h0;
    b = base_of(size, a);
    n = nbytes(size);
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      v = (v << 8) | 32'(ref_mem[b]);
      b = b + 8'd1;
    end
    if (sgn && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (sgn && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [7:0] a, input logic [31:0] d);
    logic [7:0] b;
    int         n;
    if (is_fault(size, a)) return;
    n = nbytes(size);
    b = base_of(size, a) + 8'(n - 1);
    for (int i = 0; i < n; i++) begin
      ref_mem[b] = d[7:0];
      d = d >> 8;
      b = b - 8'd1;
    end
  endtask

  // Drive one cycle of stimulus, push the expectation, compare on the response.
  task automatic cycle(input string tag, input logic v, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    exp_t got;
    @(negedge clk);
    req_valid = v; req_we = we; req_size = size; req_signed = sgn; addr = a; data_in = d;
    e.rsp = v & ~we;
    e.err = v & is_fault(size, a);
    if (v && !we) last_data = model_load(size, sgn, a);
    e.data = last_data;
    if (v && ref_busy != 8'hFF) ref_busy = ref_busy + 8'd1;
    e.busy = ref_busy;
    if (v && we) model_store(size, a, d);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".rsp"},  32'(rsp_valid), 32'(got.rsp));
    chk({tag, ".err"},  32'(err),       32'(got.err));
    chk({tag, ".data"}, data_out,       got.data);
    chk({tag, ".busy"}, 32'(busy_cnt),  32'(got.busy));
    req_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] busy_before;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; addr = 8'h00; data_in = 32'h0;
    last_data = 32'h0; ref_busy = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.data", data_out, 32'h0);
    chk("reset.rsp",  32'(rsp_valid), 32'h0);
    chk("reset.err",  32'(err), 32'h0);
    chk("reset.busy", 32'(busy_cnt), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Initialise every location with word stores.
    for (int i = 0; i < 64; i++)
      cycle("fill", 1'b1, 1'b1, 2'b10, 1'b0, 8'(i * 4), $urandom);

    cycle("st_w10", 1'b1, 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF);
    cycle("ld_w10", 1'b1, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    chk("spec_w10", data_out, 32'hDEADBEEF);
    cycle("ld_b13u", 1'b1, 1'b0, 2'b00, 1'b0, 8'h13, 32'h0);
    chk("spec_b13u", data_out, 32'h000000EF);
    cycle("ld_b10s", 1'b1, 1'b0, 2'b00, 1'b1, 8'h10, 32'h0);
    chk("spec_b10s", data_out, 32'hFFFFFFDE);
    cycle("ld_h12s", 1'b1, 1'b0, 2'b01, 1'b1, 8'h12, 32'h0);
    chk("spec_h12s", data_out, 32'hFFFFBEEF);
    cycle("ld_h12u", 1'b1, 1'b0, 2'b01, 1'b0, 8'h12, 32'h0);
    chk("spec_h12u", data_out, 32'h0000BEEF);
    cycle("idle", 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
    chk("spec_idle_hold", data_out, 32'h0000BEEF);
    cycle("st_b11", 1'b1, 1'b1, 2'b00, 1'b0, 8'h11, 32'hAABBCC55);
    cycle("ld_w10b", 1'b1, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    chk("spec_w10b", data_out, 32'hDE55BEEF);
    cycle("ld_w11", 1'b1, 1'b0, 2'b10, 1'b0, 8'h11, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("spec_w11_err", 32'(err), 32'h1);
    chk("spec_w11_data", data_out, 32'h0);
`else
    chk("spec_w11_err", 32'(err), 32'h0);
    chk("spec_w11_data", data_out, 32'hDE55BEEF);
`endif
    busy_before = busy_cnt;
    cycle("st_rsv20", 1'b1, 1'b1, 2'b11, 1'b0, 8'h20, 32'h12345678);
    chk("spec_rsv_err", 32'(err), 32'h1);
    cycle("ld_w20", 1'b1, 1'b0, 2'b10, 1'b0, 8'h20, 32'h0);
    chk("spec_rsv_busy", 32'(busy_cnt), 32'(busy_before + 8'd2));
    cycle("ld_rsv", 1'b1, 1'b0, 2'b11, 1'b1, 8'h10, 32'h0);
    chk("spec_rsv_ld", data_out, 32'h0);

    // Load issued during reset is dropped; RAM survives.
    @(negedge clk);
    reset_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; addr = 8'h10;
    @(posedge clk);
    #1;
    chk("rst_ld.rsp",  32'(rsp_valid), 32'h0);
    chk("rst_ld.data", data_out, 32'h0);
    chk("rst_ld.busy", 32'(busy_cnt), 32'h0);
    @(negedge clk);
    reset_n = 1'b1; req_valid = 1'b0;
    last_data = 32'h0; ref_busy = 8'h00;
    cycle("ld_after_rst", 1'b1, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    chk("spec_after_rst", data_out, 32'hDE55BEEF);

    // Wrap at the top of the address space.
    cycle("st_bff", 1'b1, 1'b1, 2'b00, 1'b0, 8'hFF, 32'h000000A5);
    cycle("ld_bffs", 1'b1, 1'b0, 2'b00, 1'b1, 8'hFF, 32'h0);

    // Random mix; long enough to saturate busy_cnt.
    for (int i = 0; i < 300; i++)
      cycle("rnd", ($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom),
            1'($urandom), 8'($urandom), $urandom);
    chk("busy_sat", 32'(busy_cnt), 32'h000000FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
